// File: rtl/rvx_spi_engine_pkg.sv
// Shared types and constants for the SPI register-bus engine: FSM state encoding,
// controller register map and per-state bus decode helpers.
package rvx_spi_engine_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_CS_WR      = 4'd1,
      ST_CS_WAIT    = 4'd2,
      ST_DATA_WR    = 4'd3,
      ST_DATA_WAIT  = 4'd4,
      ST_SETTLE     = 4'd5,
      ST_BUSY_RD    = 4'd6,
      ST_BUSY_WAIT  = 4'd7,
      ST_RX_RD      = 4'd8,
      ST_RX_WAIT    = 4'd9,
      ST_RX_PUSH    = 4'd10,
      ST_DESEL_WR   = 4'd11,
      ST_DESEL_WAIT = 4'd12
   } state_t;

   localparam logic [4:0] REG_CHIP_SELECT = 5'h08;
   localparam logic [4:0] REG_WDATA       = 5'h10;
   localparam logic [4:0] REG_RDATA       = 5'h14;
   localparam logic [4:0] REG_BUSY        = 5'h18;
   localparam logic [7:0] DESELECT        = 8'hFF;

   // Address held on the bus for a request state and its wait state.
   function automatic logic [4:0] state_addr(input state_t s);
      case (s)
         ST_CS_WR, ST_CS_WAIT, ST_DESEL_WR, ST_DESEL_WAIT: state_addr = REG_CHIP_SELECT;
         ST_DATA_WR, ST_DATA_WAIT:                        state_addr = REG_WDATA;
         ST_BUSY_RD, ST_BUSY_WAIT:                        state_addr = REG_BUSY;
         ST_RX_RD, ST_RX_WAIT:                            state_addr = REG_RDATA;
         default:                                         state_addr = 5'h00;
      endcase
   endfunction

   function automatic logic is_wr_state(input state_t s);
      case (s)
         ST_CS_WR, ST_DATA_WR, ST_DESEL_WR: is_wr_state = 1'b1;
         default:                           is_wr_state = 1'b0;
      endcase
   endfunction

   function automatic logic is_rd_state(input state_t s);
      case (s)
         ST_BUSY_RD, ST_RX_RD: is_rd_state = 1'b1;
         default:              is_rd_state = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rvx_spi_engine_fifo.sv
// Small synchronous RX FIFO with wrap-bit pointers; head is read combinationally.
// Push while full is accepted only together with a pop in the same cycle.
module rvx_spi_engine_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;

   // Pointer update; reset flushes the queue.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/rvx_spi_engine.sv
// Byte-stream to SPI-controller register-bus engine with an RX FIFO stream output.
// Optional macro RVX_SPI_ENGINE_RX_SKIP_EN adds tx_skip_rx to suppress read-back per byte.
module rvx_spi_engine
   import rvx_spi_engine_pkg::*;
#(
   parameter int RX_FIFO_DEPTH = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  cs_index,
   input  logic [7:0]  tx_data,
   input  logic        tx_last,
   input  logic        tx_valid,
`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
   input  logic        tx_skip_rx,
`endif
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        active,
   output logic [4:0]  spi_rw_address,
   input  logic [31:0] spi_read_data,
   output logic        spi_read_request,
   input  logic        spi_read_response,
   output logic [7:0]  spi_write_data,
   output logic [3:0]  spi_write_strobe,
   output logic        spi_write_request,
   input  logic        spi_write_response
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t      r_state, w_state_n;
   logic [7:0]  r_byte, w_byte_n;
   logic        r_last, w_last_n;
   logic        r_skip, w_skip_n;
   logic [7:0]  r_cs, w_cs_n;
   logic        r_active, w_active_n;
   logic [7:0]  r_settle, w_settle_n;
   logic [7:0]  r_rx_byte, w_rx_byte_n;
   logic        r_tx_ready;
   logic        r_rd_req;
   logic        r_wr_req;
   logic [3:0]  r_strobe;
   logic [4:0]  r_addr;
   logic [7:0]  r_wdata, w_wdata_n;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic        w_skip_in;
   logic        w_unused_rd;

`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
   assign w_skip_in = tx_skip_rx;
`else
   assign w_skip_in = 1'b0;
`endif

   assign w_unused_rd = ^spi_read_data[31:8];
   assign w_pop       = rx_ready && !w_empty;

   rvx_spi_engine_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (r_rx_byte),
      .i_pop   (w_pop),
      .o_data  (rx_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state and next-register decode.
   always_comb begin
      w_state_n   = r_state;
      w_byte_n    = r_byte;
      w_last_n    = r_last;
      w_skip_n    = r_skip;
      w_cs_n      = r_cs;
      w_active_n  = r_active;
      w_settle_n  = r_settle;
      w_rx_byte_n = r_rx_byte;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tx_valid && r_tx_ready) begin
               w_byte_n = tx_data;
               w_last_n = tx_last;
               w_skip_n = w_skip_in;
               if (!r_active) begin
                  w_cs_n    = cs_index;
                  w_state_n = ST_CS_WR;
               end else begin
                  w_state_n = ST_DATA_WR;
               end
            end else begin
               w_state_n = ST_IDLE;
            end
         end
         ST_CS_WR:   w_state_n = ST_CS_WAIT;
         ST_CS_WAIT: begin
            if (spi_write_response) begin
               w_active_n = 1'b1;
               w_state_n  = ST_DATA_WR;
            end else begin
               w_state_n = ST_CS_WAIT;
            end
         end
         ST_DATA_WR:   w_state_n = ST_DATA_WAIT;
         ST_DATA_WAIT: begin
            if (spi_write_response) begin
               w_settle_n = 8'd0;
               w_state_n  = (SETTLE_CYCLES == 0) ? ST_BUSY_RD : ST_SETTLE;
            end else begin
               w_state_n = ST_DATA_WAIT;
            end
         end
         ST_SETTLE: begin
            if (r_settle == SETTLE_LAST) begin
               w_state_n = ST_BUSY_RD;
            end else begin
               w_settle_n = r_settle + 8'd1;
            end
         end
         ST_BUSY_RD:   w_state_n = ST_BUSY_WAIT;
         ST_BUSY_WAIT: begin
            if (!spi_read_response) begin
               w_state_n = ST_BUSY_WAIT;
            end else if (spi_read_data[0]) begin
               w_state_n = ST_BUSY_RD;
            end else if (r_skip) begin
               w_state_n = r_last ? ST_DESEL_WR : ST_IDLE;
            end else begin
               w_state_n = ST_RX_RD;
            end
         end
         ST_RX_RD:   w_state_n = ST_RX_WAIT;
         ST_RX_WAIT: begin
            if (spi_read_response) begin
               w_rx_byte_n = spi_read_data[7:0];
               w_state_n   = ST_RX_PUSH;
            end else begin
               w_state_n = ST_RX_WAIT;
            end
         end
         // A pop in the same cycle frees the slot this push lands in.
         ST_RX_PUSH: begin
            if (!w_full || w_pop) begin
               w_push    = 1'b1;
               w_state_n = r_last ? ST_DESEL_WR : ST_IDLE;
            end else begin
               w_state_n = ST_RX_PUSH;
            end
         end
         ST_DESEL_WR:   w_state_n = ST_DESEL_WAIT;
         ST_DESEL_WAIT: begin
            if (spi_write_response) begin
               w_active_n = 1'b0;
               w_state_n  = ST_IDLE;
            end else begin
               w_state_n = ST_DESEL_WAIT;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Write data accompanying the request about to be issued.
   always_comb begin
      w_wdata_n = r_wdata;
      case (w_state_n)
         ST_CS_WR:    w_wdata_n = w_cs_n;
         ST_DATA_WR:  w_wdata_n = w_byte_n;
         ST_DESEL_WR: w_wdata_n = DESELECT;
         default:     w_wdata_n = r_wdata;
      endcase
   end

   // State and registered bus outputs, decoded from the next state so they align with it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_byte     <= 8'h00;
         r_last     <= 1'b0;
         r_skip     <= 1'b0;
         r_cs       <= 8'h00;
         r_active   <= 1'b0;
         r_settle   <= 8'h00;
         r_rx_byte  <= 8'h00;
         r_tx_ready <= 1'b0;
         r_rd_req   <= 1'b0;
         r_wr_req   <= 1'b0;
         r_strobe   <= 4'h0;
         r_addr     <= 5'h00;
         r_wdata    <= 8'h00;
      end else begin
         r_state    <= w_state_n;
         r_byte     <= w_byte_n;
         r_last     <= w_last_n;
         r_skip     <= w_skip_n;
         r_cs       <= w_cs_n;
         r_active   <= w_active_n;
         r_settle   <= w_settle_n;
         r_rx_byte  <= w_rx_byte_n;
         r_tx_ready <= (w_state_n == ST_IDLE);
         r_rd_req   <= is_rd_state(w_state_n);
         r_wr_req   <= is_wr_state(w_state_n);
         r_strobe   <= is_wr_state(w_state_n) ? 4'hF : 4'h0;
         r_addr     <= state_addr(w_state_n);
         r_wdata    <= w_wdata_n;
      end
   end

   assign tx_ready          = r_tx_ready;
   assign rx_valid          = !w_empty;
   assign active            = r_active;
   assign spi_rw_address    = r_addr;
   assign spi_read_request  = r_rd_req;
   assign spi_write_request = r_wr_req;
   assign spi_write_strobe  = r_strobe;
   assign spi_write_data    = r_wdata;

endmodule

// File: tb/tb_rvx_spi_engine.sv
// Directed bench for rvx_spi_engine with a behavioural loopback SPI controller model.
module tb_rvx_spi_engine;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  cs_index;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        tx_valid;
`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
   logic        tx_skip_rx;
`endif
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        active;
   logic [4:0]  spi_rw_address;
   logic [31:0] spi_read_data;
   logic        spi_read_request;
   logic        spi_read_response;
   logic [7:0]  spi_write_data;
   logic [3:0]  spi_write_strobe;
   logic        spi_write_request;
   logic        spi_write_response;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   rvx_spi_engine #(.RX_FIFO_DEPTH(4), .SETTLE_CYCLES(2)) dut (
      .clock              (clock),
      .reset              (reset),
      .cs_index           (cs_index),
      .tx_data            (tx_data),
      .tx_last            (tx_last),
      .tx_valid           (tx_valid),
`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
      .tx_skip_rx         (tx_skip_rx),
`endif
      .tx_ready           (tx_ready),
      .rx_data            (rx_data),
      .rx_valid           (rx_valid),
      .rx_ready           (rx_ready),
      .active             (active),
      .spi_rw_address     (spi_rw_address),
      .spi_read_data      (spi_read_data),
      .spi_read_request   (spi_read_request),
      .spi_read_response  (spi_read_response),
      .spi_write_data     (spi_write_data),
      .spi_write_strobe   (spi_write_strobe),
      .spi_write_request  (spi_write_request),
      .spi_write_response (spi_write_response)
   );

   // Controller model: one-cycle responses, loopback RDATA, BUSY held for m_xfer cycles.
   logic [12:0] wr_log [$];
   logic [4:0]  rd_log [$];
   logic [7:0]  m_byte;
   int          m_busy_cnt;
   int          m_xfer;
   int          busy1_reads;
   int          rd_while_busy;
   int          proto_err;
   logic        prev_wr, prev_rd;

   always @(posedge clock) begin
      if (!reset) begin
         spi_write_response <= 1'b0;
         spi_read_response  <= 1'b0;
         spi_read_data      <= 32'h0;
         m_busy_cnt         <= 0;
         prev_wr            <= 1'b0;
         prev_rd            <= 1'b0;
      end else begin
         spi_write_response <= spi_write_request;
         spi_read_response  <= spi_read_request;
         prev_wr            <= spi_write_request;
         prev_rd            <= spi_read_request;
         if ((spi_write_request && prev_wr) || (spi_read_request && prev_rd))
            proto_err <= proto_err + 1;
         if (spi_write_strobe !== (spi_write_request ? 4'hF : 4'h0))
            proto_err <= proto_err + 1;
         if (spi_write_request) begin
            wr_log.push_back({spi_rw_address, spi_write_data});
            if (spi_rw_address == 5'h10) begin
               m_byte     <= spi_write_data;
               m_busy_cnt <= m_xfer;
            end
         end else if (m_busy_cnt > 0) begin
            m_busy_cnt <= m_busy_cnt - 1;
         end
         if (spi_read_request) begin
            rd_log.push_back(spi_rw_address);
            if (spi_rw_address == 5'h18) begin
               spi_read_data <= {31'h0, (m_busy_cnt != 0)};
               if (m_busy_cnt != 0) busy1_reads <= busy1_reads + 1;
            end else if (spi_rw_address == 5'h14) begin
               spi_read_data <= {24'h0, m_byte};
               if (m_busy_cnt != 0) rd_while_busy <= rd_while_busy + 1;
            end else begin
               spi_read_data <= 32'hDEAD_BEEF;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte and return at the negedge after it was accepted.
   task automatic send(input logic [7:0] cs, input logic [7:0] d, input logic l, input logic skip);
      logic got;
      got = 1'b0;
      cs_index = cs; tx_data = d; tx_last = l; tx_valid = 1'b1;
`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
      tx_skip_rx = skip;
`else
      got = skip & 1'b0;
`endif
      for (int n = 0; n < 600; n++) begin
         if (tx_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      @(negedge clock);
      tx_valid = 1'b0;
      chk("send_accept", {31'h0, got}, 32'd1);
   endtask

   task automatic wait_ready(input string tag);
      for (int n = 0; n < 600; n++) begin
         if (tx_ready) break;
         @(negedge clock);
      end
      chk(tag, {31'h0, tx_ready}, 32'd1);
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      chk({tag, "_valid"}, {31'h0, rx_valid}, 32'd1);
      chk({tag, "_data"}, {24'h0, rx_data}, {24'h0, exp});
      rx_ready = 1'b1;
      @(negedge clock);
      rx_ready = 1'b0;
   endtask

   task automatic count_wr(input logic [4:0] a, output int c);
      c = 0;
      foreach (wr_log[i]) if (wr_log[i][12:8] == a) c++;
   endtask

   task automatic count_rd(input logic [4:0] a, output int c);
      c = 0;
      foreach (rd_log[i]) if (rd_log[i] == a) c++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c;
      logic found;
      reset = 1'b0; cs_index = 8'h00; tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
      rx_ready = 1'b0; m_xfer = 3; busy1_reads = 0; rd_while_busy = 0; proto_err = 0;
`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
      tx_skip_rx = 1'b0;
`endif
      repeat (3) @(negedge clock);
      chk("rst_tx_ready", {31'h0, tx_ready}, 32'd0);
      chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
      chk("rst_active", {31'h0, active}, 32'd0);
      chk("rst_reqs", {30'h0, spi_read_request, spi_write_request}, 32'd0);
      chk("rst_addr", {27'h0, spi_rw_address}, 32'd0);
      chk("rst_wdata", {24'h0, spi_write_data}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rel_tx_ready", {31'h0, tx_ready}, 32'd1);

      // Single-byte frame
      wr_log.delete(); rd_log.delete();
      send(8'h00, 8'hA5, 1'b1, 1'b0);
      wait_ready("t1_done");
      chk("t1_active", {31'h0, active}, 32'd0);
      chk("t1_nwr", wr_log.size(), 32'd3);
      chk("t1_wr0", {19'h0, wr_log[0]}, {19'h0, 5'h08, 8'h00});
      chk("t1_wr1", {19'h0, wr_log[1]}, {19'h0, 5'h10, 8'hA5});
      chk("t1_wr2", {19'h0, wr_log[2]}, {19'h0, 5'h08, 8'hFF});
      count_rd(5'h14, c);
      chk("t1_rdata_reads", c, 32'd1);
      pop("t1_rx", 8'hA5);
      chk("t1_empty", {31'h0, rx_valid}, 32'd0);

      // Three-byte frame
      wr_log.delete(); rd_log.delete();
      send(8'h03, 8'h01, 1'b0, 1'b0);
      wait_ready("t2_b1");
      chk("t2_active_mid", {31'h0, active}, 32'd1);
      send(8'h03, 8'h02, 1'b0, 1'b0);
      wait_ready("t2_b2");
      send(8'h03, 8'h03, 1'b1, 1'b0);
      wait_ready("t2_b3");
      chk("t2_active_end", {31'h0, active}, 32'd0);
      count_wr(5'h08, c);
      chk("t2_cs_writes", c, 32'd2);
      chk("t2_nwr", wr_log.size(), 32'd5);
      chk("t2_first", {19'h0, wr_log[0]}, {19'h0, 5'h08, 8'h03});
      chk("t2_last", {19'h0, wr_log[4]}, {19'h0, 5'h08, 8'hFF});
      pop("t2_rx0", 8'h01);
      pop("t2_rx1", 8'h02);
      pop("t2_rx2", 8'h03);
      chk("t2_empty", {31'h0, rx_valid}, 32'd0);

      // Backpressure: depth 4, six bytes, consumer stalled
      send(8'h01, 8'h10, 1'b0, 1'b0); wait_ready("t3_b0");
      send(8'h01, 8'h11, 1'b0, 1'b0); wait_ready("t3_b1");
      send(8'h01, 8'h12, 1'b0, 1'b0); wait_ready("t3_b2");
      send(8'h01, 8'h13, 1'b0, 1'b0); wait_ready("t3_b3");
      send(8'h01, 8'h14, 1'b0, 1'b0);
      repeat (25) @(negedge clock);
      chk("t3_park_ready", {31'h0, tx_ready}, 32'd0);
      chk("t3_park_active", {31'h0, active}, 32'd1);
      pop("t3_rx0", 8'h10);
      wait_ready("t3_b4");
      send(8'h01, 8'h15, 1'b1, 1'b0);
      repeat (25) @(negedge clock);
      chk("t3_park2_ready", {31'h0, tx_ready}, 32'd0);
      pop("t3_rx1", 8'h11);
      wait_ready("t3_b5");
      chk("t3_active_end", {31'h0, active}, 32'd0);
      pop("t3_rx2", 8'h12);
      pop("t3_rx3", 8'h13);
      pop("t3_rx4", 8'h14);
      pop("t3_rx5", 8'h15);
      chk("t3_empty", {31'h0, rx_valid}, 32'd0);

      // Busy polling with a slow transfer
      m_xfer = 64; busy1_reads = 0; rd_while_busy = 0;
      send(8'h02, 8'h5A, 1'b1, 1'b0);
      wait_ready("t4_done");
      chk("t4_multi_busy", {31'h0, (busy1_reads >= 2)}, 32'd1);
      chk("t4_rd_while_busy", rd_while_busy, 32'd0);
      pop("t4_rx", 8'h5A);

      // Reset during BUSY_WAIT with an entry already queued
      m_xfer = 3;
      send(8'h02, 8'h77, 1'b1, 1'b0);
      wait_ready("t5_pre");
      m_xfer = 200;
      send(8'h02, 8'h88, 1'b0, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (spi_read_request && spi_rw_address == 5'h18) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk("t5_busy_rd_seen", {31'h0, found}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("t5_reqs", {30'h0, spi_read_request, spi_write_request}, 32'd0);
      chk("t5_active", {31'h0, active}, 32'd0);
      chk("t5_rx_valid", {31'h0, rx_valid}, 32'd0);
      chk("t5_tx_ready_in_rst", {31'h0, tx_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("t5_tx_ready", {31'h0, tx_ready}, 32'd1);
      m_xfer = 3;

`ifdef RVX_SPI_ENGINE_RX_SKIP_EN
      wr_log.delete(); rd_log.delete();
      send(8'h04, 8'h3C, 1'b1, 1'b1);
      wait_ready("t6_done");
      count_rd(5'h14, c);
      chk("t6_no_rdata", c, 32'd0);
      chk("t6_rx_valid", {31'h0, rx_valid}, 32'd0);
      chk("t6_nwr", wr_log.size(), 32'd3);
      tx_skip_rx = 1'b0;
`endif

      chk("protocol", proto_err, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
